sm_result_collector: RTL
========================

# sm_result_collector

Receiving end of the stack machine's result port. Samples the `d_valid`/`out_data`/`err_code`/`fin` stream the stack machine produces, buffers results in a small FIFO and presents them on a ready/valid read port. It also keeps a result count, an overflow flag and the first error code, and reports program completion once `fin` is seen and the buffer has drained. It sits between the stack machine and the display/host logic in the top level.

## Interface
- `DEPTH`, 16: FIFO entries (power of two).
- `DW`, 20: result width; must match the stack machine data width.
- `CW`, 10: result counter width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `clear`  in  1  synchronous restart for the next program.
- `d_valid`  in  1  result strobe from the stack machine.
- `out_data`  in  DW  result word; sampled only when `d_valid`=1.
- `err_code`  in  3  stack machine error code; 0 means no error.
- `fin`  in  1  stack machine program-finished level.
- `rd_ready`  in  1  downstream ready.
- `rd_valid`  out  1  head entry available.
- `rd_data`  out  DW  head entry; 0 when empty.
- `rd_last`  out  1  head entry is the final result of the program.
- `level`  out  5  FIFO occupancy, 0..DEPTH.
- `count`  out  CW  `d_valid` pulses accepted in the collect phase; saturates at 2^CW-1.
- `overflow`  out  1  sticky: a result was dropped.
- `err_latched`  out  3  first nonzero `err_code` seen; sticky.
- `done`  out  1  program complete and buffer empty.

## Operation
- Priority order: `rst_n`, then `clear`, then normal operation. `clear` empties the FIFO, zeroes `count`, `overflow` and `err_latched`, and sets the state to IDLE. A `d_valid` in the same cycle as `clear` is discarded.
- States:
  - IDLE. `d_valid`=1 moves to COLLECT and writes the word. `fin`=1 with no `d_valid` moves to DRAIN (empty program).
  - COLLECT. `fin`=1 moves to DRAIN.
  - DRAIN. Moves to DONE when `level`=0.
  - DONE. Held until `clear`.
- `d_valid` and `fin` high together in IDLE or COLLECT: the word is written first, then the state moves to DRAIN.
- Write: `d_valid`=1 in IDLE or COLLECT. `count`+1 (saturating).
  - If `level`<DEPTH, or a pop happens in the same cycle, the word is written.
  - Otherwise the word is dropped and `overflow` is set.
- `d_valid` in DRAIN or DONE is ignored: no write, no count, no flag.
- Pop: `rd_valid`&&`rd_ready`. FIFO is first-word-fall-through: `rd_data` is the head entry, driven combinationally from storage.
- Push and pop in the same cycle: `level` is unchanged; this is legal when the FIFO is full.
- `rd_last` = `rd_valid` && state==DRAIN && `level`==1.
- `err_latched` samples `err_code` every cycle in IDLE or COLLECT. The first nonzero value is held until reset or `clear`.
- `done` = (state==DONE).
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full versus empty is decided by `level`, not by pointer equality.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_last`=0, `level`=0, `count`=0, `overflow`=0, `err_latched`=0, `done`=0, state IDLE. These take effect immediately on `rst_n` falling, without waiting for `clk`.
- Write latency: a word sampled at edge N gives `rd_valid`=1 and valid `rd_data` after edge N.
- Pop at edge N: the next entry, or `rd_valid`=0, is visible after edge N.
- `fin` sampled at edge N: state is DRAIN after edge N.
- DRAIN with `level`=0 at edge M: `done`=1 after edge M.
- Minimum for an empty program: `fin` at edge N gives `done` after edge N+1.
- Reset asserted mid-operation, including during DRAIN: all contents are lost and outputs return to reset values asynchronously.

## Test plan
1. Results: push 5, 0xFFFFD, 42 with `rd_ready`=0, then `fin`=1 → `level`=3, `count`=3, `rd_data`=5. Then `rd_ready`=1 → 5, 0xFFFFD, 42 on consecutive cycles, `rd_last`=1 only with 42, `done`=1 one cycle after the last pop.
2. Overflow: 17 `d_valid` pulses with `rd_ready`=0 → `level`=16, `count`=17, `overflow`=1. Draining returns the first 16 words in order.
3. Push and pop together at full: `level` stays 16, `overflow` stays 0, order is preserved.
4. Empty program: `fin`=1 in IDLE → `done`=1 two edges later, `count`=0, `rd_valid` never asserts.
5. Errors: `err_code`=3'b010 for one cycle, later 3'b101 → `err_latched`=3'b010. `clear` → 0.
6. Reset: drop `rst_n` mid-drain with `level`=4 → all outputs 0 before the next edge. After release, a new program collects normally. `clear` asserted together with `d_valid` → word discarded, `count`=0.

Source files
------------

// File: rtl/sm_result_collector.sv
// Result collector: buffers stack machine results in a FWFT FIFO.
// Ports: clk/rst_n/clear, result stream in, rd_* read port, status out.
module sm_result_collector #(
  parameter int DEPTH = 16,
  parameter int DW    = 20,
  parameter int CW    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     d_valid,
  input  logic [DW-1:0]            out_data,
  input  logic [2:0]               err_code,
  input  logic                     fin,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CW-1:0]            count,
  output logic                     overflow,
  output logic [2:0]               err_latched,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [2:0]      err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic collecting;
  logic wr_req;
  logic full;
  logic pop;
  logic push;

  assign collecting = (state_q == IDLE) || (state_q == COLLECT);
  assign full       = (level_q == LW'(DEPTH));
  assign rd_valid   = (level_q != '0);
  assign pop        = rd_valid && rd_ready && !clear;
  // A write at full still fits if the head leaves this cycle.
  assign wr_req     = d_valid && collecting && !clear;
  assign push       = wr_req && (!full || pop);

  assign rd_data     = rd_valid ? mem_q[rptr_q] : '0;
  assign rd_last     = rd_valid && (state_q == DRAIN)
                       && (level_q == LW'(1));
  assign level       = level_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign err_latched = err_q;
  assign done        = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    if (clear) begin
      state_d = IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      err_d   = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);

      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      if (wr_req && (count_q != '1))
        count_d = count_q + CW'(1);
      if (wr_req && !push)
        ovf_d = 1'b1;

      if (collecting && (err_q == '0))
        err_d = err_code;

      unique case (state_q)
        IDLE: begin
          if (fin)          state_d = DRAIN;
          else if (d_valid) state_d = COLLECT;
        end
        COLLECT: begin
          if (fin) state_d = DRAIN;
        end
        DRAIN: begin
          if (level_q == '0) state_d = DONE;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: contents are only visible while level > 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= out_data;
  end

endmodule
